// File: rtl/y86_bus_arbiter_if.sv
// Bus bundle shared by the two y86 bus masters, the arbiter and the external memory model.
// The slave modport is the arbiter's view; the master modport is the masters/memory side.
interface y86_bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          m0_req;
    logic          m1_req;
    logic          m0_we;
    logic          m1_we;
    logic [AW-1:0] m0_addr;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m0_wdata;
    logic [DW-1:0] m1_wdata;
    logic          m0_gnt;
    logic          m1_gnt;
    logic          m0_done;
    logic          m1_done;
    logic          m0_err;
    logic          m1_err;
    logic [DW-1:0] m_rdata;
    logic [AW-1:0] mem_A;
    logic [DW-1:0] mem_out;
    logic          mem_RE;
    logic          mem_WE;
    logic [DW-1:0] mem_in;
    logic          mem_ready;

    modport slave (
        input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
        input  mem_in, mem_ready,
        output m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err, m_rdata,
        output mem_A, mem_out, mem_RE, mem_WE
    );

    modport master (
        output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
        output mem_in, mem_ready,
        input  m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err, m_rdata,
        input  mem_A, mem_out, mem_RE, mem_WE
    );
endinterface

// File: rtl/y86_bus_arbiter.sv
// Two-master round-robin arbiter for the y86 memory bus: latches one request, runs the
// ready/wait handshake with a timeout, and returns data plus a done/err pulse to the owner.
module y86_bus_arbiter #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int TO_MAX = 15
) (
    input  logic             clk,
    input  logic             rst,
    y86_bus_arbiter_if.slave bus
);

    localparam int            CW   = $clog2(TO_MAX + 1);
    localparam logic [CW-1:0] TO_C = CW'(TO_MAX);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    state_e        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_owner_q, last_owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [AW-1:0] mem_a_q, mem_a_d;
    logic [DW-1:0] mem_out_q, mem_out_d;
    logic          mem_re_q, mem_re_d;
    logic          mem_we_q, mem_we_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [1:0]    done_q, done_d;
    logic [1:0]    err_q, err_d;
    logic          win;

    // The memory-side registers double as the latched request: they hold the winner's
    // addr/wdata/direction for the whole ACCESS phase and are zero in every other state.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        mem_a_d      = mem_a_q;
        mem_out_d    = mem_out_q;
        mem_re_d     = mem_re_q;
        mem_we_d     = mem_we_q;
        gnt_d        = '0;
        done_d       = '0;
        err_d        = '0;
        win          = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    win          = (bus.m0_req && bus.m1_req) ? ~last_owner_q : bus.m1_req;
                    owner_d      = win;
                    last_owner_d = win;
                    gnt_d[win]   = 1'b1;
                    cnt_d        = '0;
                    mem_a_d      = win ? bus.m1_addr  : bus.m0_addr;
                    mem_out_d    = win ? bus.m1_wdata : bus.m0_wdata;
                    mem_we_d     = win ? bus.m1_we    : bus.m0_we;
                    mem_re_d     = win ? ~bus.m1_we   : ~bus.m0_we;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                // Ready wins over a timeout landing on the same edge.
                if (bus.mem_ready || (cnt_q == TO_C)) begin
                    state_d   = RESP;
                    mem_a_d   = '0;
                    mem_out_d = '0;
                    mem_re_d  = 1'b0;
                    mem_we_d  = 1'b0;
                    if (bus.mem_ready) begin
                        if (mem_re_q) begin
                            rdata_d = bus.mem_in;
                        end
                        done_d[owner_q] = 1'b1;
                    end else begin
                        err_d[owner_q] = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            cnt_q        <= '0;
            rdata_q      <= '0;
            mem_a_q      <= '0;
            mem_out_q    <= '0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            gnt_q        <= '0;
            done_q       <= '0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
            mem_a_q      <= mem_a_d;
            mem_out_q    <= mem_out_d;
            mem_re_q     <= mem_re_d;
            mem_we_q     <= mem_we_d;
            gnt_q        <= gnt_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.m0_gnt  = gnt_q[0];
    assign bus.m1_gnt  = gnt_q[1];
    assign bus.m0_done = done_q[0];
    assign bus.m1_done = done_q[1];
    assign bus.m0_err  = err_q[0];
    assign bus.m1_err  = err_q[1];
    assign bus.m_rdata = rdata_q;
    assign bus.mem_A   = mem_a_q;
    assign bus.mem_out = mem_out_q;
    assign bus.mem_RE  = mem_re_q;
    assign bus.mem_WE  = mem_we_q;

endmodule

// File: tb/tb_y86_bus_arbiter.sv
// Scoreboard bench for y86_bus_arbiter: expected grants/responses are queued when a request
// is posted and compared when the arbiter pulses gnt/done/err.
module tb_y86_bus_arbiter;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int TO_MAX = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    y86_bus_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    y86_bus_arbiter #(.AW(AW), .DW(DW), .TO_MAX(TO_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit m;
        int gap;
    } gnt_t;

    typedef struct {
        bit          m;
        bit          err;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ncyc;
    } rsp_t;

    gnt_t        gnt_q[$];
    rsp_t        rsp_q[$];
    logic [31:0] mem[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] model_rdata = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int wait_cycles = 0;
    bit stuck       = 1'b0;
    bit force_ready = 1'b0;
    int gnt_cnt     = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory responder: ready after wait_cycles stalled cycles, never when stuck.
    initial begin
        int acc_cyc;
        acc_cyc       = 0;
        bus.mem_ready = 1'b0;
        bus.mem_in    = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_RE || bus.mem_WE) begin
                bus.mem_ready = !stuck && (acc_cyc >= wait_cycles);
                if (bus.mem_RE) bus.mem_in = mem.exists(bus.mem_A) ? mem[bus.mem_A] : '0;
                if (bus.mem_WE && bus.mem_ready) mem[bus.mem_A] = bus.mem_out;
                acc_cyc++;
            end else begin
                bus.mem_ready = force_ready;
                acc_cyc       = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on every grant and response pulse.
    initial begin
        int   cyc;
        int   last_gnt_cyc;
        int   strb_cyc;
        gnt_t g;
        rsp_t r;
        cyc = 0; last_gnt_cyc = 0; strb_cyc = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                strb_cyc = 0;
            end else begin
                cyc++;
                if (bus.m0_gnt || bus.m1_gnt) begin
                    if (gnt_q.size() == 0) begin
                        check("unexpected_gnt", 1, 0);
                    end else begin
                        g = gnt_q.pop_front();
                        check("gnt_who", {bus.m1_gnt, bus.m0_gnt}, g.m ? 2'b10 : 2'b01);
                        if (g.gap != 0) check("gnt_gap", cyc - last_gnt_cyc, g.gap);
                    end
                    last_gnt_cyc = cyc;
                    gnt_cnt++;
                end
                if (bus.mem_RE || bus.mem_WE) begin
                    check("strobe_excl", bus.mem_RE & bus.mem_WE, 0);
                    if (strb_cyc == 0 && rsp_q.size() != 0) begin
                        check("mem_A", bus.mem_A, rsp_q[0].addr);
                        check("mem_dir", {bus.mem_WE, bus.mem_RE}, rsp_q[0].we ? 2'b10 : 2'b01);
                        if (rsp_q[0].we) check("mem_out", bus.mem_out, rsp_q[0].wdata);
                    end
                    strb_cyc++;
                end
                if (bus.m0_done || bus.m0_err || bus.m1_done || bus.m1_err) begin
                    if (rsp_q.size() == 0) begin
                        check("unexpected_resp", 1, 0);
                    end else begin
                        r = rsp_q.pop_front();
                        check("resp_who", {bus.m1_done | bus.m1_err, bus.m0_done | bus.m0_err},
                              r.m ? 2'b10 : 2'b01);
                        check("resp_kind", {bus.m0_done | bus.m1_done, bus.m0_err | bus.m1_err},
                              r.err ? 2'b01 : 2'b10);
                        check("m_rdata", bus.m_rdata, r.rdata);
                        check("strobe_cycles", strb_cyc, r.ncyc);
                    end
                    strb_cyc = 0;
                end
            end
        end
    end

    task automatic post(input bit m, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int ncyc, input bit err, input int gap);
        rsp_t r;
        gnt_t g;
        if (!err && !we) model_rdata = ref_mem.exists(addr) ? ref_mem[addr] : '0;
        if (!err && we) ref_mem[addr] = wdata;
        r.m = m; r.err = err; r.we = we; r.addr = addr; r.wdata = wdata;
        r.rdata = model_rdata; r.ncyc = ncyc;
        rsp_q.push_back(r);
        g.m = m; g.gap = gap;
        gnt_q.push_back(g);
        if (m) begin
            bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata;
        end else begin
            bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata;
        end
    endtask

    task automatic serve(input int budget);
        int n;
        n = 0;
        while ((bus.m0_req || bus.m1_req || rsp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
            if (bus.m0_done || bus.m0_err) bus.m0_req = 1'b0;
            if (bus.m1_done || bus.m1_err) bus.m1_req = 1'b0;
        end
        check("serve_budget", n < budget, 1);
        if (n >= budget) begin
            bus.m0_req = 1'b0; bus.m1_req = 1'b0;
            rsp_q.delete(); gnt_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        model_rdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int n;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b0;
        bus.m0_req = 1'b0; bus.m1_req = 1'b0; bus.m0_we = 1'b0; bus.m1_we = 1'b0;
        bus.m0_addr = '0; bus.m1_addr = '0; bus.m0_wdata = '0; bus.m1_wdata = '0;
        mem[32'h100] = 32'hDEADBEEF; ref_mem[32'h100] = 32'hDEADBEEF;
        mem[32'h8]   = 32'h88880008; ref_mem[32'h8]   = 32'h88880008;
        mem[32'h4]   = 32'h44440004; ref_mem[32'h4]   = 32'h44440004;
        repeat (2) @(negedge clk);
        check("rst_pulses", {bus.m0_gnt, bus.m1_gnt, bus.m0_done, bus.m1_done,
                             bus.m0_err, bus.m1_err, bus.mem_RE, bus.mem_WE}, 0);
        check("rst_mem_A", bus.mem_A, 0);
        check("rst_mem_out", bus.mem_out, 0);
        check("rst_rdata", bus.m_rdata, 0);
        rst = 1'b1;
        @(negedge clk);

        // Single read with two wait states.
        wait_cycles = 2;
        post(1'b0, 1'b0, 32'h100, '0, 3, 1'b0, 0);
        bus.m0_req = 1'b1;
        serve(30);

        // Tie from reset: master 0 first, master 1 three cycles later.
        do_reset();
        wait_cycles = 0;
        post(1'b0, 1'b1, 32'h4, 32'h11, 1, 1'b0, 0);
        post(1'b1, 1'b0, 32'h8, '0, 1, 1'b0, 3);
        bus.m0_req = 1'b1; bus.m1_req = 1'b1;
        serve(30);

        // Fairness: both hold req for six accesses.
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) post(1'b0, 1'b0, 32'h4, '0, 1, 1'b0, (i == 0) ? 0 : 3);
            else            post(1'b1, 1'b0, 32'h8, '0, 1, 1'b0, 3);
        end
        n = gnt_cnt + 6;
        bus.m0_addr = 32'h4; bus.m1_addr = 32'h8;
        bus.m0_req = 1'b1; bus.m1_req = 1'b1;
        begin
            int k;
            k = 0;
            while (gnt_cnt < n && k < 60) begin
                @(negedge clk);
                k++;
            end
            check("fair_grant_budget", gnt_cnt >= n, 1);
        end
        bus.m0_req = 1'b0;
        serve(30);

        // Timeout with memory never ready.
        stuck = 1'b1;
        post(1'b1, 1'b0, 32'h20, '0, TO_MAX + 1, 1'b1, 0);
        bus.m1_req = 1'b1;
        serve(30);
        stuck = 1'b0;
        check("idle_after_err", {bus.mem_RE, bus.mem_WE, bus.mem_A != 0}, 0);

        // Asynchronous reset in the middle of an access.
        stuck = 1'b1;
        post(1'b0, 1'b0, 32'h100, '0, 0, 1'b0, 0);
        bus.m0_req = 1'b1;
        repeat (3) @(negedge clk);
        check("access_in_progress", bus.mem_RE, 1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_strobes", {bus.mem_RE, bus.mem_WE, bus.m0_done, bus.m0_err}, 0);
        check("async_rst_mem_A", bus.mem_A, 0);
        check("async_rst_rdata", bus.m_rdata, 0);
        rsp_q.delete(); gnt_q.delete();
        bus.m0_req = 1'b0; stuck = 1'b0; model_rdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        post(1'b0, 1'b0, 32'h8, '0, 1, 1'b0, 0);
        post(1'b1, 1'b0, 32'h100, '0, 1, 1'b0, 3);
        bus.m0_req = 1'b1; bus.m1_req = 1'b1;
        serve(30);

        // Request withdrawn mid-access, then stray ready in IDLE.
        wait_cycles = 1;
        post(1'b0, 1'b0, 32'h4, '0, 2, 1'b0, 0);
        bus.m0_req = 1'b1;
        n = 0;
        while (!bus.m0_gnt && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("withdraw_gnt_seen", bus.m0_gnt, 1);
        bus.m0_req = 1'b0;
        serve(30);
        force_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("stray_ready", {bus.mem_RE, bus.mem_WE, bus.m0_gnt, bus.m1_gnt,
                                  bus.m0_done, bus.m1_done, bus.m0_err, bus.m1_err}, 0);
        end
        force_ready = 1'b0;
        check("queues_drained", rsp_q.size() + gnt_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
